// File: rtl/aes_pkg.sv
// Shared AES sequencing types: FSM states, key-size codes, round-count lookup.
// Pure declarations, no timing or flow control of its own.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int MAX_NR  = 14;

  localparam logic [1:0] AES128 = 2'd0;
  localparam logic [1:0] AES192 = 2'd1;
  localparam logic [1:0] AES256 = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // Codes 2 and 3 both select AES-256.
  function automatic logic [3:0] nr_of(input logic [1:0] sel);
    case (sel)
      AES128:  nr_of = 4'd10;
      AES192:  nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_select.sv
// Combinational slice of one 128-bit round key out of the expanded-key bus.
// Zero latency, no flow control; out-of-range indices fall back to key 0.
module aes_key_select
  import aes_pkg::*;
#(
  parameter int MAX_NR    = 14,
  parameter int KEY_BUS_W = 128 * (MAX_NR + 1)
) (
  input  logic [KEY_BUS_W-1:0] allKeys,
  input  logic [3:0]           keyIdx,
  output logic [BLOCK_W-1:0]   roundKey
);

  localparam logic [3:0] MAX_IDX = 4'(MAX_NR);

  logic [BLOCK_W-1:0] keys [MAX_NR+1];

  // Key 0 occupies the most significant slice of the bus.
  for (genvar k = 0; k <= MAX_NR; k++) begin : gSlice
    assign keys[k] = allKeys[KEY_BUS_W-1-BLOCK_W*k -: BLOCK_W];
  end

  always_comb begin
    roundKey = keys[0];
    if (keyIdx <= MAX_IDX) roundKey = keys[keyIdx];
  end

endmodule

// File: rtl/aes_round_sched.sv
// Round sequencer for a shared iterative AES datapath: one block per Nr+2 cycles, ready only in IDLE/DONE.
// Optional AES_OP_COUNT_EN adds a 16-bit wrapping count of completed operations (op_count).
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int MAX_NR    = 14,
  parameter int KEY_BUS_W = 128 * (MAX_NR + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [1:0]           sel,
  input  logic                 decrypt,
  input  logic [KEY_BUS_W-1:0] all_keys,
  output logic [127:0]         round_key,
  output logic [3:0]           round_idx,
  output logic                 load_state,
  output logic                 last_round,
  output logic                 dp_en,
  output logic                 busy,
  output logic                 done
`ifdef AES_OP_COUNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  state_t     state, stateNxt;
  logic [3:0] roundIdx, roundIdxNxt;
  logic [3:0] nrQ;
  logic       decQ;
  logic       accept;
  logic [3:0] keyIdx;

  assign start_ready = ((state == IDLE) || (state == DONE)) && !reset;
  assign accept      = start_valid && start_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      roundIdx <= 4'd0;
      nrQ      <= 4'd10;
      decQ     <= 1'b0;
    end else begin
      state    <= stateNxt;
      roundIdx <= roundIdxNxt;
      if (accept) begin
        nrQ  <= nr_of(sel);
        decQ <= decrypt;
      end
    end
  end

  always_comb begin
    stateNxt    = state;
    roundIdxNxt = roundIdx;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNxt    = LOAD;
          roundIdxNxt = 4'd0;
        end
      end
      LOAD, ROUND: begin
        roundIdxNxt = roundIdx + 4'd1;
        stateNxt    = (roundIdx + 4'd1 == nrQ) ? FINAL : ROUND;
      end
      FINAL: stateNxt = DONE;
      DONE: begin
        // Back-to-back acceptance skips IDLE; otherwise park with index 0.
        stateNxt    = accept ? LOAD : IDLE;
        roundIdxNxt = 4'd0;
      end
      default: begin
        stateNxt    = IDLE;
        roundIdxNxt = 4'd0;
      end
    endcase
  end

  assign round_idx  = roundIdx;
  assign load_state = (state == LOAD);
  assign last_round = (state == FINAL);
  assign busy       = (state == LOAD) || (state == ROUND) || (state == FINAL);
  assign dp_en      = busy;
  assign done       = (state == DONE);

  // Decryption walks the schedule backwards; roundIdx never exceeds nrQ.
  assign keyIdx = decQ ? (nrQ - roundIdx) : roundIdx;

  aes_key_select #(
    .MAX_NR   (MAX_NR),
    .KEY_BUS_W(KEY_BUS_W)
  ) uKeySelect (
    .allKeys (all_keys),
    .keyIdx  (keyIdx),
    .roundKey(round_key)
  );

`ifdef AES_OP_COUNT_EN
  logic [15:0] opCount;

  always_ff @(posedge clk) begin
    if (reset) opCount <= 16'd0;
    else if (state == DONE) opCount <= opCount + 16'd1;
  end

  assign op_count = opCount;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized and directed bench for aes_round_sched against a cycle-count reference model.
module tb_aes_round_sched;

  localparam int MAX_NR    = 14;
  localparam int KEY_BUS_W = 128 * (MAX_NR + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start_valid;
  logic                 start_ready;
  logic [1:0]           sel;
  logic                 decrypt;
  logic [KEY_BUS_W-1:0] all_keys;
  logic [127:0]         round_key;
  logic [3:0]           round_idx;
  logic                 load_state;
  logic                 last_round;
  logic                 dp_en;
  logic                 busy;
  logic                 done;
`ifdef AES_OP_COUNT_EN
  logic [15:0]          op_count;
`endif

  aes_round_sched #(
    .MAX_NR   (MAX_NR),
    .KEY_BUS_W(KEY_BUS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .sel        (sel),
    .decrypt    (decrypt),
    .all_keys   (all_keys),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .load_state (load_state),
    .last_round (last_round),
    .dp_en      (dp_en),
    .busy       (busy),
    .done       (done)
`ifdef AES_OP_COUNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] keyArr [MAX_NR+1];

  // Model: mCyc = cycles since acceptance (-1 when idle), mNr/mDec latched per op.
  int          mCyc;
  int          mNr;
  bit          mDec;
  int unsigned mCnt;

  task automatic chkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle-in-op %0d, Nr %0d)", tag, got, exp, mCyc, mNr);
    end
  endtask

  function automatic int nrOfSel(input logic [1:0] s);
    if (s == 2'd0) return 10;
    if (s == 2'd1) return 12;
    return 14;
  endfunction

  task automatic randKeys();
    for (int k = 0; k <= MAX_NR; k++) begin
      keyArr[k] = {$urandom, $urandom, $urandom, $urandom};
      all_keys[KEY_BUS_W-1-128*k -: 128] = keyArr[k];
    end
  endtask

  function automatic bit mReady();
    return ((mCyc < 0) || (mCyc == mNr + 1)) && !reset;
  endfunction

  task automatic checkOutputs();
    bit act, dn;
    int idx, k;
    act = (mCyc >= 0) && (mCyc <= mNr);
    dn  = (mCyc == mNr + 1);
    chkEq("start_ready", 128'(start_ready), 128'(mReady()));
    chkEq("busy",        128'(busy),        128'(act));
    chkEq("dp_en",       128'(dp_en),       128'(act));
    chkEq("load_state",  128'(load_state),  128'(mCyc == 0));
    chkEq("last_round",  128'(last_round),  128'(mCyc == mNr));
    chkEq("done",        128'(done),        128'(dn));
    if (act || dn) begin
      idx = dn ? mNr : mCyc;
      k   = mDec ? (mNr - idx) : idx;
      chkEq("round_idx", 128'(round_idx), 128'(idx));
      chkEq("round_key", round_key, keyArr[k]);
    end
    if (reset && (mCyc < 0)) begin
      chkEq("reset_idx", 128'(round_idx), 128'(0));
      chkEq("reset_key", round_key, keyArr[0]);
    end
`ifdef AES_OP_COUNT_EN
    chkEq("op_count", 128'(op_count), 128'(mCnt));
`endif
  endtask

  // One clock: model observes the inputs present at the edge, then outputs are checked.
  task automatic step();
    bit acc;
    acc = start_valid && mReady();
    @(posedge clk);
    if (reset) begin
      mCyc = -1;
      mCnt = 0;
    end else begin
      if (mCyc == mNr + 1) mCnt = (mCnt + 1) & 32'hFFFF;
      if (acc) begin
        mCyc = 0;
        mNr  = nrOfSel(sel);
        mDec = decrypt;
      end else if (mCyc >= 0) begin
        mCyc++;
        if (mCyc > mNr + 1) mCyc = -1;
      end
    end
    #1;
    checkOutputs();
  endtask

  // Single-cycle start pulse, then scrambled sel/decrypt while the op runs.
  task automatic runOp(input logic [1:0] s, input bit d, input int tail);
    start_valid = 1'b1;
    sel         = s;
    decrypt     = d;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < tail; i++) begin
      sel     = 2'($urandom);
      decrypt = 1'($urandom);
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    sel         = 2'd0;
    decrypt     = 1'b0;
    all_keys    = '0;
    mCyc        = -1;
    mNr         = 10;
    mDec        = 1'b0;
    mCnt        = 0;
    randKeys();

    repeat (2) step();
    reset = 1'b0;
    #1;
    chkEq("ready_after_init", 128'(start_ready), 128'(1));
    step();

    runOp(2'd0, 1'b0, 14);
    runOp(2'd1, 1'b1, 16);
    runOp(2'd3, 1'b0, 18);

    // Held start_valid: three back-to-back AES-128 blocks.
    start_valid = 1'b1;
    sel         = 2'd0;
    decrypt     = 1'b0;
    repeat (36) step();
    start_valid = 1'b0;
    repeat (3) step();

    // Reset in the middle of an operation, at round index 5.
    start_valid = 1'b1;
    sel         = 2'd2;
    decrypt     = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) begin
      sel     = ~sel;
      decrypt = ~decrypt;
      step();
    end
    chkEq("reached_idx5", 128'(round_idx), 128'(5));
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chkEq("ready_after_abort", 128'(start_ready), 128'(1));
    repeat (3) step();

`ifdef AES_OP_COUNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) runOp(2'($urandom), 1'($urandom), 17);
    chkEq("op_count_three", 128'(op_count), 128'(3));
    reset = 1'b1;
    step();
    chkEq("op_count_reset", 128'(op_count), 128'(0));
    reset = 1'b0;
    step();
    force dut.opCount = 16'hFFFF;
    #1;
    release dut.opCount;
    mCnt = 32'hFFFF;
    runOp(2'd0, 1'b0, 13);
    chkEq("op_count_wrap", 128'(op_count), 128'(0));
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) randKeys();
      start_valid = ($urandom_range(0, 3) != 0);
      sel         = 2'($urandom);
      decrypt     = 1'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset       = 1'b0;
    start_valid = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
